// File: rtl/sr_latch_driver.sv
// sr_latch_driver
// Drive-side controller for a gate-level SR latch. Single-cycle set/reset
// requests become mutually exclusive S/R pulses of PULSE_W cycles. Each pulse
// is followed by a GAP_W-cycle recovery window with S=R=0. A one-cycle CHECK
// then compares the synchronized latch output against the expected state.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   set_req   request a set pulse (taken only while ready)
//   rst_req   request a reset pulse (taken only while ready)
//   err_clr   clears the sticky err flag
//   q_fb      latch Q, asynchronous to clk
//   S, R      registered latch drives, never high together
//   ready     idle and able to accept a request
//   done      one-cycle pulse after a command's check
//   conflict  one-cycle pulse when both requests arrive while idle
//   exp_q     expected latch state after the last accepted command
//   err       sticky: checked Q differed from exp_q

module sr_latch_driver #(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned GAP_W   = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic rst_req,
    input  logic err_clr,
    input  logic q_fb,
    output logic S,
    output logic R,
    output logic ready,
    output logic done,
    output logic conflict,
    output logic exp_q,
    output logic err
);

    localparam logic [7:0] PulseLoad = 8'(PULSE_W - 1);
    localparam logic [7:0] GapLoad   = 8'(GAP_W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPulse,
        StGap,
        StCheck
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       s_q, s_d;
    logic       r_q, r_d;
    logic       done_q, done_d;
    logic       conflict_q, conflict_d;
    logic       exp_state_q, exp_state_d;
    logic       err_q, err_d;
    logic       sync1_q, sync2_q;

    // Two-flop synchronizer for the asynchronous latch output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= q_fb;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        s_d         = 1'b0;
        r_d         = 1'b0;
        done_d      = 1'b0;
        conflict_d  = 1'b0;
        exp_state_d = exp_state_q;
        err_d       = err_q & ~err_clr;

        case (state_q)
            StIdle: begin
                if (set_req && rst_req) begin
                    conflict_d = 1'b1;
                end else if (set_req) begin
                    exp_state_d = 1'b1;
                    s_d         = 1'b1;
                    cnt_d       = PulseLoad;
                    state_d     = StPulse;
                end else if (rst_req) begin
                    exp_state_d = 1'b0;
                    r_d         = 1'b1;
                    cnt_d       = PulseLoad;
                    state_d     = StPulse;
                end
            end
            StPulse: begin
                if (cnt_q == 8'd0) begin
                    cnt_d   = GapLoad;
                    state_d = StGap;
                end else begin
                    // Hold whichever drive was selected on entry; the other stays 0.
                    cnt_d = cnt_q - 8'd1;
                    s_d   = s_q;
                    r_d   = r_q;
                end
            end
            StGap: begin
                if (cnt_q == 8'd0) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StCheck: begin
                // A mismatch overrides a simultaneous err_clr.
                if (sync2_q != exp_state_q) begin
                    err_d = 1'b1;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            s_q         <= 1'b0;
            r_q         <= 1'b0;
            done_q      <= 1'b0;
            conflict_q  <= 1'b0;
            exp_state_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s_q         <= s_d;
            r_q         <= r_d;
            done_q      <= done_d;
            conflict_q  <= conflict_d;
            exp_state_q <= exp_state_d;
            err_q       <= err_d;
        end
    end

    assign S        = s_q;
    assign R        = r_q;
    assign ready    = (state_q == StIdle);
    assign done     = done_q;
    assign conflict = conflict_q;
    assign exp_q    = exp_state_q;
    assign err      = err_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench for sr_latch_driver. A behavioural SR latch sits on
// S/R/q_fb; a timeline model (command edge + fixed offsets) predicts every
// output each cycle.

module tb_sr_latch_driver;

    localparam int PW = 2;
    localparam int GW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic set_req = 1'b0;
    logic rst_req = 1'b0;
    logic err_clr = 1'b0;
    logic q_fb;
    logic S, R, ready, done, conflict, exp_q, err;

    logic force_low = 1'b0;
    logic lat = 1'b0;

    int checks = 0;
    int errors = 0;

    // Model state: n counts rising edges; "cycle n" is the period after edge n.
    int n = 0;
    int cmd_edge = -1000;
    bit cmd_set = 1'b0;
    bit m_exp = 1'b0;
    bit m_err = 1'b0;
    bit m_conf = 1'b0;
    bit q_e1 = 1'b0;
    bit q_e2 = 1'b0;
    bit q_now;

    sr_latch_driver #(
        .PULSE_W(PW),
        .GAP_W  (GW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_req (set_req),
        .rst_req (rst_req),
        .err_clr (err_clr),
        .q_fb    (q_fb),
        .S       (S),
        .R       (R),
        .ready   (ready),
        .done    (done),
        .conflict(conflict),
        .exp_q   (exp_q),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Behavioural SR latch.
    always @(S, R) begin
        if (S) lat = 1'b1;
        else if (R) lat = 1'b0;
    end
    assign q_fb = force_low ? 1'b0 : lat;

    function automatic bit m_idle(input int c);
        return c >= cmd_edge + PW + GW + 1;
    endfunction

    task automatic chk(input string tag, input logic got, input logic want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b cycle=%0d", tag, got, want, n);
        end
    endtask

    task automatic model_reset();
        cmd_edge = -1000;
        m_exp = 1'b0;
        m_err = 1'b0;
        m_conf = 1'b0;
        q_e1 = 1'b0;
        q_e2 = 1'b0;
    endtask

    task automatic model_edge(input bit bs, input bit br, input bit bc, input bit qn);
        bit is_check;
        bit mismatch;
        n++;
        m_conf = 1'b0;
        // The synchronizer compared at edge n holds q_fb as seen at edge n-2.
        is_check = (n == cmd_edge + PW + GW + 1);
        mismatch = is_check && (q_e2 != m_exp);
        if (m_idle(n - 1)) begin
            if (bs && br) begin
                m_conf = 1'b1;
            end else if (bs || br) begin
                cmd_edge = n;
                cmd_set = bs;
                m_exp = bs;
            end
        end
        if (mismatch) m_err = 1'b1;
        else if (bc) m_err = 1'b0;
        q_e2 = q_e1;
        q_e1 = qn;
    endtask

    task automatic check_all();
        bit in_pulse;
        in_pulse = (n >= cmd_edge) && (n <= cmd_edge + PW - 1);
        chk("S", S, in_pulse && cmd_set);
        chk("R", R, in_pulse && !cmd_set);
        chk("S_and_R", S & R, 1'b0);
        chk("ready", ready, m_idle(n));
        chk("done", done, n == cmd_edge + PW + GW + 1);
        chk("conflict", conflict, m_conf);
        chk("exp_q", exp_q, m_exp);
        chk("err", err, m_err);
    endtask

    // Inputs are stable from the preceding negedge; outputs checked at negedge.
    task automatic step();
        q_now = q_fb;
        @(posedge clk);
        model_edge(set_req, rst_req, err_clr, q_now);
        @(negedge clk);
        check_all();
    endtask

    task automatic check_reset_values();
        chk("rst_S", S, 1'b0);
        chk("rst_R", R, 1'b0);
        chk("rst_ready", ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_conflict", conflict, 1'b0);
        chk("rst_exp_q", exp_q, 1'b0);
        chk("rst_err", err, 1'b0);
    endtask

    task automatic idle_steps(input int k);
        set_req = 1'b0;
        rst_req = 1'b0;
        err_clr = 1'b0;
        for (int i = 0; i < k; i++) step();
    endtask

    initial begin
        // Reset state, checked before any clock edge.
        #1;
        check_reset_values();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_steps(2);

        // Set command: S for PW cycles, done six cycles after the request.
        set_req = 1'b1;
        step();
        idle_steps(8);

        // Reset command: R pulse, latch falls.
        rst_req = 1'b1;
        step();
        idle_steps(8);

        // Simultaneous requests while idle.
        set_req = 1'b1;
        rst_req = 1'b1;
        step();
        idle_steps(3);

        // Stuck-low feedback: set fails its check, err stays through a good reset.
        force_low = 1'b1;
        set_req = 1'b1;
        step();
        idle_steps(8);
        rst_req = 1'b1;
        step();
        idle_steps(8);
        err_clr = 1'b1;
        step();
        idle_steps(2);

        // Mismatch and err_clr on the same edge: mismatch wins.
        set_req = 1'b1;
        step();
        set_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            err_clr = (i == PW + GW);
            step();
        end
        idle_steps(2);
        force_low = 1'b0;

        // Requests toggling during pulse/gap are ignored.
        set_req = 1'b1;
        step();
        for (int i = 0; i < PW + GW + 1; i++) begin
            set_req = i[0];
            rst_req = ~i[0];
            step();
        end
        idle_steps(4);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            set_req = ($urandom_range(0, 3) == 0);
            rst_req = ($urandom_range(0, 3) == 0);
            err_clr = ($urandom_range(0, 7) == 0);
            if ((i % 40) == 0) force_low = ($urandom_range(0, 2) == 0);
            step();
        end
        force_low = 1'b0;
        idle_steps(8);

        // Asynchronous reset while S is high.
        set_req = 1'b1;
        step();
        set_req = 1'b0;
        step();
        chk("mid_pulse_S_high", S, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_steps(1);
        set_req = 1'b1;
        step();
        idle_steps(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Drive-side controller for the team's gate-level SR latch.
- Turns single-cycle set/reset requests from synchronous logic into clean, mutually exclusive S and R pulses of programmed width.
- Enforces a recovery gap after each pulse, then samples the latch's Q through a synchronizer and checks it against the expected state.
- Guarantees the latch never sees the forbidden S=1/R=1 combination.

Parameters:
- PULSE_W, 2, cycles S or R is held high per command; legal range 1..255.
- GAP_W, 2, recovery cycles with S=R=0 after a pulse, before the check; legal range 2..255, so the synchronizer output is settled before sampling.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- set_req  input  1  request a set pulse; accepted only when ready=1.
- rst_req  input  1  request a reset pulse; accepted only when ready=1.
- err_clr  input  1  clears the sticky err flag.
- q_fb  input  1  latch Q output; asynchronous to clk.
- S  output  1  set drive to the latch.
- R  output  1  reset drive to the latch.
- ready  output  1  high when in IDLE and able to accept a request.
- done  output  1  one-cycle pulse when a command's check completes.
- conflict  output  1  one-cycle pulse when set_req and rst_req are both high in an accepting cycle.
- exp_q  output  1  expected latch state after the last accepted command.
- err  output  1  sticky flag: the checked Q did not match exp_q.

Behaviour:
- Reset (rst_n=0, asynchronous): S=0, R=0, ready=1, done=0, conflict=0, exp_q=0, err=0. FSM goes to IDLE, the pulse counter clears, and both synchronizer flops clear to 0.
  - Reset mid-pulse drops S and R to 0 immediately, without waiting for a clock edge.
- q_fb passes through a 2-flop synchronizer to give q_sync. It is used only in CHECK.
- FSM states: IDLE, PULSE, GAP, CHECK.
- IDLE, ready=1:
  - set_req=1, rst_req=0 at edge t: exp_q<=1, go to PULSE with S selected.
  - rst_req=1, set_req=0 at edge t: exp_q<=0, go to PULSE with R selected.
  - Both high: no command issued, conflict=1 for cycle t+1, stay in IDLE, exp_q unchanged.
  - Neither high: stay in IDLE.
- PULSE:
  - The selected output (S or R) is high for exactly PULSE_W cycles, starting in cycle t+1. The other output stays 0.
  - S and R are registered outputs. S&R=1 is never produced under any input.
  - ready=0. Requests arriving in this state are ignored, not queued.
- GAP: S=R=0 for exactly GAP_W cycles. ready=0.
- CHECK, one cycle, ready=0:
  - Sample q_sync. If q_sync!=exp_q, set err<=1.
  - Assert done in the following cycle, when the FSM returns to IDLE and ready=1.
- Command latency: request edge t gives pulse in cycles t+1..t+PULSE_W, gap in cycles t+PULSE_W+1..t+PULSE_W+GAP_W, CHECK in cycle t+PULSE_W+GAP_W+1, and done/ready in cycle t+PULSE_W+GAP_W+2.
- Redundant command (set while exp_q=1, or reset while exp_q=0): the full pulse/gap/check sequence still runs.
- err flag:
  - Cleared by err_clr=1 at a clock edge.
  - If err_clr and a mismatch occur in the same cycle, the mismatch wins and err stays 1.
  - err does not block further commands.
- Counter: 8-bit down-counter, loaded with PULSE_W-1 on entry to PULSE and with GAP_W-1 on entry to GAP. The state advances when the counter is 0.

Test Plan:
- Reset release, then set_req for 1 cycle with PULSE_W=2, GAP_W=2, and a behavioural SR latch model on S/R/q_fb -> S high exactly 2 cycles starting the cycle after the request; R stays 0; done pulses 6 cycles after the request edge; exp_q=1, err=0, ready=1.
- After the set, issue rst_req -> R high 2 cycles, S=0 throughout; exp_q=0; q_fb falls; done pulses; err=0.
- set_req=1 and rst_req=1 together in IDLE -> conflict=1 for one cycle; S=R=0; exp_q and ready unchanged.
- q_fb tied to 0, then set_req -> err=1 after CHECK and stays 1 through a later good reset command. err_clr=1 -> err=0 next cycle.
- Toggle set_req/rst_req every cycle during PULSE and GAP -> no additional pulses and no queued command; only the first accepted command executes; S&R=0 at every cycle.
- Assert rst_n=0 mid-pulse (S high) -> S drops to 0 before the next clk edge; all outputs take their reset values; ready=1 after release.
